// File: rtl/lsu_sequencer.sv
// lsu_sequencer: load/store sequencer between the control FSM and the memory port.
// Define LSU_MISALIGN_SPLIT_EN to split bus-boundary-crossing accesses into two beats.
//   state | meaning
//   IDLE  | ready, waiting for a request
//   ACC1  | first (or only) bus beat
//   ACC2  | second beat of a split access
//   RESP  | one-cycle completion pulse
module lsu_sequencer #(
  parameter int          BUS_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_fault,
  output logic [31:0]          mem_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [BUS_W/8-1:0]   mem_byte_enable,
  output logic [BUS_W-1:0]     mem_wdata,
  input  logic [BUS_W-1:0]     mem_rdata,
  input  logic                 mem_resp
);
  localparam int BE_W  = BUS_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 32'd0 : TIMEOUT - 32'd1);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t             state_q, state_d;
  logic               we_q, fault_q;
  logic [2:0]         f3_q;
  logic [31:0]        addr_q, wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BUS_W-1:0]   rd1_q;

  logic               req_legal, req_bad, tmo_hit;
  logic [OFF_W-1:0]   off_q;
  logic [BE_W-1:0]    mask_q, be_lo;
  logic [BUS_W-1:0]   wd_lo;
  logic [2*BUS_W-1:0] rd_all;
  logic [31:0]        aligned, raw, ext;

  always_comb begin
    if (req_we) req_legal = (req_funct3 <= 3'd2);
    else        req_legal = (req_funct3 <= 3'd2) || (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
  end

  assign off_q   = addr_q[OFF_W-1:0];
  assign aligned = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && !mem_resp;

  always_comb begin
    case (f3_q[1:0])
      2'd0:    mask_q = BE_W'(1);
      2'd1:    mask_q = BE_W'(3);
      default: mask_q = BE_W'(15);
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [2*BE_W-1:0]  be_full;
  logic [2*BUS_W-1:0] wd_full;
  logic [BE_W-1:0]    be_hi;
  logic [BUS_W-1:0]   wd_hi, rd2_q;
  logic               cross_q;

  assign req_bad = !req_legal;
  // Shift across a double-width window; the upper half is what spills into beat two.
  assign be_full = {{BE_W{1'b0}}, mask_q} << off_q;
  assign wd_full = {{BUS_W{1'b0}}, BUS_W'(wdata_q)} << {off_q, 3'b000};
  assign be_lo   = be_full[BE_W-1:0];
  assign be_hi   = be_full[2*BE_W-1:BE_W];
  assign wd_lo   = wd_full[BUS_W-1:0];
  assign wd_hi   = wd_full[2*BUS_W-1:BUS_W];
  assign cross_q = |be_hi;
  assign rd_all  = {rd2_q, rd1_q};
`else
  logic req_misalign;
  assign req_misalign = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                        (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
  assign req_bad = !req_legal || req_misalign;
  assign be_lo   = mask_q << off_q;
  assign wd_lo   = BUS_W'(wdata_q) << {off_q, 3'b000};
  assign rd_all  = {{BUS_W{1'b0}}, rd1_q};
`endif

  assign raw = 32'(rd_all >> {off_q, 3'b000});

  always_comb begin
    case (f3_q)
      3'd0:    ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    ext = {{16{raw[15]}}, raw[15:0]};
      3'd4:    ext = {24'd0, raw[7:0]};
      3'd5:    ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = '0;
    rsp_fault       = 1'b0;
    mem_addr        = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_bad ? RESP : ACC1;
      end
      ACC1: begin
        mem_addr        = aligned;
        mem_read        = !we_q;
        mem_write       = we_q;
        mem_byte_enable = be_lo;
        mem_wdata       = wd_lo;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (mem_resp)     state_d = cross_q ? ACC2 : RESP;
`else
        if (mem_resp)     state_d = RESP;
`endif
        else if (tmo_hit) state_d = RESP;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ACC2: begin
        mem_addr        = aligned + 32'(BE_W);
        mem_read        = !we_q;
        mem_write       = we_q;
        mem_byte_enable = be_hi;
        mem_wdata       = wd_hi;
        if (mem_resp || tmo_hit) state_d = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        rsp_fault = fault_q;
        rsp_rdata = (fault_q || we_q) ? 32'd0 : ext;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rd1_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      rd2_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if ((state_q == ACC1 || state_q == ACC2) && !mem_resp)
        cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          fault_q <= req_bad;
        end
        ACC1: begin
          if (mem_resp)     rd1_q   <= mem_rdata;
          else if (tmo_hit) fault_q <= 1'b1;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ACC2: begin
          if (mem_resp)     rd2_q   <= mem_rdata;
          else if (tmo_hit) fault_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer: vector table plus scoreboard queues for
// bus beats and responses, with hand-written timeout, reset and 64-bit sequences.
module tb_lsu_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_fault, mem_read, mem_write;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata = 0;
  logic        mem_resp = 0;

  logic        b_req_valid = 0, b_req_we = 0;
  logic [2:0]  b_req_funct3 = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_fault, b_mem_read, b_mem_write;
  logic [31:0] b_rsp_rdata, b_mem_addr;
  logic [7:0]  b_mem_byte_enable;
  logic [63:0] b_mem_wdata;
  logic [63:0] b_mem_rdata = 0;
  logic        b_mem_resp = 0;

  lsu_sequencer #(.BUS_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp));

  lsu_sequencer #(.BUS_W(64)) dut64 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
    .mem_addr(b_mem_addr), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_byte_enable(b_mem_byte_enable), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp));

  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] addr, wdata, d1, d2;
    int delay, nbeats;
    logic [31:0] a1; logic [3:0] be1; logic [31:0] wd1;
    logic [31:0] a2; logic [3:0] be2; logic [31:0] wd2;
    logic [31:0] rdata; logic fault;
  } vec_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } beat_t;
  typedef struct { logic [31:0] rdata; logic fault; } rsp_t;

  vec_t  vq[$];
  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  int    errors = 0, checks = 0, strobe_cnt = 0;
  logic  rsp_prev = 0;
  beat_t mb;
  rsp_t  mr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] wdata, input logic [31:0] d1, input logic [31:0] d2, input int delay,
      input int nbeats, input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
      input logic [31:0] a2, input logic [3:0] be2, input logic [31:0] wd2,
      input logic [31:0] rdata, input logic fault);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.d1 = d1; v.d2 = d2;
    v.delay = delay; v.nbeats = nbeats; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    v.a2 = a2; v.be2 = be2; v.wd2 = wd2; v.rdata = rdata; v.fault = fault;
    return v;
  endfunction

  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      strobe_cnt++;
      if (rsp_valid) chk("strobe_in_resp", 1'b1, 1'b0 ^ rsp_valid ^ 1'b1);
      if (mem_resp) begin
        checks++;
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got beat at 0x%0h expected none", mem_addr);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_dir", {mem_write, mem_read}, mb.we ? 2'b10 : 2'b01);
          chk("beat_addr", mem_addr, mb.addr);
          chk("beat_be", mem_byte_enable, mb.be);
          if (mb.we) chk("beat_wdata", mem_wdata, mb.wd);
        end
      end
    end
    if (rsp_valid) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp rdata 0x%0h expected none", rsp_rdata);
      end else begin
        mr = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mr.rdata);
        chk("rsp_fault", rsp_fault, mr.fault);
      end
      if (rsp_prev) chk("rsp_pulse_len", {rsp_prev, rsp_valid}, 2'b01);
    end
    rsp_prev = rsp_valid;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 40) begin tick(); n++; end
    chk(nm, req_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int s0, n;
    beat_t b;
    rsp_t r;
    wait_ready($sformatf("v%0d_ready_pre", idx));
    s0 = strobe_cnt;
    r.rdata = v.rdata; r.fault = v.fault; rsp_q.push_back(r);
    if (v.nbeats > 0) begin b.we = v.we; b.addr = v.a1; b.be = v.be1; b.wd = v.wd1; beat_q.push_back(b); end
    if (v.nbeats > 1) begin b.we = v.we; b.addr = v.a2; b.be = v.be2; b.wd = v.wd2; beat_q.push_back(b); end
    req_valid = 1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    tick();
    req_valid = 0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 0; k < v.nbeats; k++) begin
      n = 0;
      while (!(mem_read || mem_write) && n < 20) begin tick(); n++; end
      chk($sformatf("v%0d_strobe_seen", idx), mem_read || mem_write, 1'b1);
      repeat (v.delay) tick();
      mem_rdata = (k == 0) ? v.d1 : v.d2; mem_resp = 1;
      tick();
      mem_resp = 0; mem_rdata = $urandom;
    end
    wait_ready($sformatf("v%0d_ready_post", idx));
    chk($sformatf("v%0d_strobe_cycles", idx), 64'(strobe_cnt - s0), 64'(v.nbeats * (v.delay + 1)));
  endtask

  initial begin
    int s0;
    rsp_t r;
    vq.push_back(mk(0, 2, 32'h100, 0, 32'hDEADBEEF, 0, 2, 1, 32'h100, 4'hF, 0, 0, 0, 0, 32'hDEADBEEF, 0));
    vq.push_back(mk(0, 0, 32'h103, 0, 32'h80123456, 0, 0, 1, 32'h100, 4'h8, 0, 0, 0, 0, 32'hFFFFFF80, 0));
    vq.push_back(mk(0, 4, 32'h103, 0, 32'h80123456, 0, 1, 1, 32'h100, 4'h8, 0, 0, 0, 0, 32'h00000080, 0));
    vq.push_back(mk(0, 3, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 1, 32'h102, 32'h1234ABCD, 0, 0, 1, 1, 32'h100, 4'hC, 32'hABCD0000, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h102, 0, 32'h8001FFFF, 0, 0, 1, 32'h100, 4'hC, 0, 0, 0, 0, 32'hFFFF8001, 0));
    vq.push_back(mk(0, 5, 32'h100, 0, 32'h00009234, 0, 2, 1, 32'h100, 4'h3, 0, 0, 0, 0, 32'h00009234, 0));
    vq.push_back(mk(1, 0, 32'h101, 32'hAABBCCDD, 0, 0, 0, 1, 32'h100, 4'h2, 32'hBBCCDD00, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 4, 32'h100, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 6, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 2, 32'h204, 32'h0BADC0DE, 0, 0, 0, 1, 32'h204, 4'hF, 32'h0BADC0DE, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 2, 32'h200, 0, 32'h0BADF00D, 0, 3, 1, 32'h200, 4'hF, 0, 0, 0, 0, 32'h0BADF00D, 0));
    vq.push_back(mk(0, 7, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef LSU_MISALIGN_SPLIT_EN
    vq.push_back(mk(0, 2, 32'h103, 0, 32'h11223344, 32'h55667788, 0, 2, 32'h100, 4'h8, 0, 32'h104, 4'h7, 0, 32'h66778811, 0));
    vq.push_back(mk(0, 1, 32'h101, 0, 32'h00FE1200, 0, 1, 1, 32'h100, 4'h6, 0, 0, 0, 0, 32'hFFFFFE12, 0));
    vq.push_back(mk(1, 2, 32'h102, 32'hCAFEF00D, 0, 0, 1, 2, 32'h100, 4'hC, 32'hF00D0000, 32'h104, 4'h3, 32'h0000CAFE, 0, 0));
    vq.push_back(mk(0, 1, 32'h103, 0, 32'hAA000000, 32'h000000BB, 0, 2, 32'h100, 4'h8, 0, 32'h104, 4'h1, 0, 32'hFFFFBBAA, 0));
`else
    vq.push_back(mk(0, 2, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 32'h101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 2, 32'h102, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 1, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

    tick();
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_ctl", {rsp_valid, rsp_fault, mem_read, mem_write}, 4'b0000);
    chk("reset_bus", {mem_addr, mem_byte_enable, mem_wdata}, 68'd0);
    @(posedge clk); #3; rst = 1;
    tick();

    foreach (vq[i]) run_vec(vq[i], i);

    // no response at all: beat must give up after TIMEOUT cycles
    wait_ready("tmo_ready_pre");
    s0 = strobe_cnt;
    r.rdata = 0; r.fault = 1; rsp_q.push_back(r);
    req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h200;
    tick();
    req_valid = 0;
    wait_ready("tmo_ready_post");
    chk("tmo_strobe_cycles", 64'(strobe_cnt - s0), 64'd4);

    // asynchronous reset in the middle of a store beat
    req_valid = 1; req_we = 1; req_funct3 = 3'd1; req_addr = 32'h102; req_wdata = 32'h1234ABCD;
    tick();
    req_valid = 0;
    chk("rstmid_write_before", mem_write, 1'b1);
    #2; rst = 0; #1;
    chk("rstmid_ctl", {mem_write, mem_read, rsp_valid, rsp_fault}, 4'b0000);
    chk("rstmid_bus", {mem_addr, mem_byte_enable, mem_wdata}, 68'd0);
    chk("rstmid_ready", req_ready, 1'b1);
    chk("rstmid_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #3; rst = 1;
    tick();
    run_vec(vq[0], 100);

    s0 = strobe_cnt;
    mem_resp = 1; mem_rdata = 32'h5A5A5A5A;
    tick(); tick();
    mem_resp = 0;
    tick();
    chk("idle_resp_strobes", 64'(strobe_cnt - s0), 64'd0);
    chk("idle_resp_ready", req_ready, 1'b1);
    run_vec(vq[2], 101);

    // 64-bit bus instance
    b_req_valid = 1; b_req_we = 1; b_req_funct3 = 3'd2; b_req_addr = 32'h10C; b_req_wdata = 32'h12345678;
    tick();
    b_req_valid = 0;
    chk("w64_sw_write", {b_mem_write, b_mem_read}, 2'b10);
    chk("w64_sw_addr", b_mem_addr, 32'h108);
    chk("w64_sw_be", b_mem_byte_enable, 8'hF0);
    chk("w64_sw_wdata", b_mem_wdata, 64'h12345678_00000000);
    b_mem_resp = 1; tick(); b_mem_resp = 0;
    chk("w64_sw_rsp", {b_rsp_valid, b_rsp_fault, b_rsp_rdata}, {2'b10, 32'd0});
    tick();
    b_req_valid = 1; b_req_we = 0; b_req_funct3 = 3'd2; b_req_addr = 32'h104;
    tick();
    b_req_valid = 0;
    chk("w64_lw_bus", {b_mem_read, b_mem_addr, b_mem_byte_enable}, {1'b1, 32'h100, 8'hF0});
    b_mem_rdata = 64'hCAFEBABE_00000000; b_mem_resp = 1; tick(); b_mem_resp = 0;
    chk("w64_lw_rsp", {b_rsp_valid, b_rsp_fault, b_rsp_rdata}, {2'b10, 32'hCAFEBABE});
    tick();
    b_req_valid = 1; b_req_we = 0; b_req_funct3 = 3'd1; b_req_addr = 32'h10E;
    tick();
    b_req_valid = 0;
    chk("w64_lh_bus", {b_mem_read, b_mem_addr, b_mem_byte_enable}, {1'b1, 32'h108, 8'hC0});
    b_mem_rdata = 64'h9ABC0000_00000000; b_mem_resp = 1; tick(); b_mem_resp = 0;
    chk("w64_lh_rsp", {b_rsp_valid, b_rsp_fault, b_rsp_rdata}, {2'b10, 32'hFFFF9ABC});
    tick();
    chk("w64_ready_end", b_req_ready, 1'b1);

    chk("beat_q_drained", 64'(beat_q.size()), 64'd0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before 200000");
    $fatal(1, "watchdog");
  end
endmodule
